// File: rtl/uart_pkg.sv
// Shared constants for the UART tick generator and a baud-rate to divisor helper.
package uart_pkg;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int          DEFAULT_DIV = 650;
    localparam int          OVS         = 16;
    localparam int          OVS_W       = 4;
    localparam int          FAST_DIV    = 4;
    localparam int          MIN_DIV     = 2;

    // Rounded CLK_HZ / (baud * OVS).
    function automatic int unsigned baud_to_div(input int unsigned baud);
        int unsigned den;
        den = baud * OVS;
        return (CLK_HZ + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_tick_gen_if.sv
// Control and tick bundle between the tick generator and its UART consumers.
interface uart_tick_gen_if #(
    parameter int DIV_W = 16,
    parameter int OVS_W = 4
);
    logic             enable;
    logic             restart;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             div_pending;
    logic [DIV_W-1:0] div_cur;
    logic             sample_tick;
    logic [OVS_W-1:0] sample_idx;
    logic             mid_tick;
    logic             baud_tick;
    logic             fast_tick;

    modport master (
        output enable, restart, div_in, div_load,
        input  div_pending, div_cur, sample_tick, sample_idx, mid_tick, baud_tick, fast_tick
    );

    modport slave (
        input  enable, restart, div_in, div_load,
        output div_pending, div_cur, sample_tick, sample_idx, mid_tick, baud_tick, fast_tick
    );
endinterface

// File: rtl/uart_tick_gen_mod_counter.sv
// Modulo-N counter with run-time N, enable, synchronous clear and a registered wrap pulse.
module mod_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] n,
    output logic         wrap,
    output logic         wrap_pulse
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;

    // >= rather than == so a shrunken N can never strand the count above it.
    assign wrap = en && !clr && (cnt_q >= n - W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap_pulse = wrap_q;
endmodule

// File: rtl/uart_tick_gen.sv
// Sysclk-domain UART enable generator: oversample, mid-bit, baud and fast ticks
// with a run-time divisor that switches only at a sample boundary or restart.
module uart_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
    parameter int OVS         = uart_pkg::OVS,
    parameter int OVS_W       = uart_pkg::OVS_W,
    parameter int FAST_DIV    = uart_pkg::FAST_DIV,
    parameter int MIN_DIV     = uart_pkg::MIN_DIV
) (
    input  logic            sysclk,
    input  logic            reset,
    uart_tick_gen_if.slave  bus
);
    import uart_pkg::*;

    localparam int FAST_W = (FAST_DIV < 2) ? 1 : $clog2(FAST_DIV + 1);

    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic [OVS_W-1:0] sidx_q, sidx_d;
    logic [OVS_W-1:0] sample_idx_q, sample_idx_d;
    logic             mid_q, mid_d;
    logic             baud_q, baud_d;
    logic [DIV_W-1:0] div_clamped;
    logic             samp_wrap;
    logic             sample_tick;
    logic             fast_tick;
    logic             fast_wrap_unused;

    mod_counter #(.W(DIV_W)) u_sample_cnt (
        .clk        (sysclk),
        .rst        (reset),
        .en         (bus.enable),
        .clr        (bus.restart),
        .n          (div_cur_q),
        .wrap       (samp_wrap),
        .wrap_pulse (sample_tick)
    );

    mod_counter #(.W(FAST_W)) u_fast_cnt (
        .clk        (sysclk),
        .rst        (reset),
        .en         (1'b1),
        .clr        (1'b0),
        .n          (FAST_W'(FAST_DIV)),
        .wrap       (fast_wrap_unused),
        .wrap_pulse (fast_tick)
    );

    assign div_clamped = (bus.div_in < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div_in;

    always_comb begin
        div_cur_d    = div_cur_q;
        pend_val_d   = pend_val_q;
        pend_d       = pend_q;
        sidx_d       = sidx_q;
        sample_idx_d = sample_idx_q;
        mid_d        = 1'b0;
        baud_d       = 1'b0;
        if (bus.restart) begin
            sidx_d = '0;
            // A load coinciding with restart bypasses the pending stage entirely.
            if (bus.div_load) begin
                div_cur_d = div_clamped;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                div_cur_d = pend_val_q;
                pend_d    = 1'b0;
            end
        end else begin
            if (samp_wrap) begin
                sidx_d       = sidx_q + OVS_W'(1);
                sample_idx_d = sidx_q;
                mid_d        = (sidx_q == OVS_W'(OVS / 2 - 1));
                baud_d       = (sidx_q == OVS_W'(OVS - 1));
                if (pend_q) begin
                    div_cur_d = pend_val_q;
                    pend_d    = 1'b0;
                end
            end
            // Evaluated after the wrap so a load on a wrap edge waits for the next one.
            if (bus.div_load) begin
                pend_val_d = div_clamped;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cur_q    <= DIV_W'(DEFAULT_DIV);
            pend_val_q   <= DIV_W'(DEFAULT_DIV);
            pend_q       <= 1'b0;
            sidx_q       <= '0;
            sample_idx_q <= '0;
            mid_q        <= 1'b0;
            baud_q       <= 1'b0;
        end else begin
            div_cur_q    <= div_cur_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
            sidx_q       <= sidx_d;
            sample_idx_q <= sample_idx_d;
            mid_q        <= mid_d;
            baud_q       <= baud_d;
        end
    end

    assign bus.div_pending = pend_q;
    assign bus.div_cur     = div_cur_q;
    assign bus.sample_tick = sample_tick;
    assign bus.sample_idx  = sample_idx_q;
    assign bus.mid_tick    = mid_q;
    assign bus.baud_tick   = baud_q;
    assign bus.fast_tick   = fast_tick;
endmodule
